// File: rtl/delay_line_ctrl.sv
// Single-SRAM audio delay line controller: writes each dry sample to a ring on port 0 and reads it back on port 1.
// Optional build macro DELAY_MIX_EN: output becomes sat(dry + wet/2) instead of the wet sample alone.
module delay_line_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic        [ADDR_WIDTH-1:0] delay_len,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_sample,
  output logic                         csb0,
  output logic                         web0,
  output logic        [ADDR_WIDTH-1:0] addr0,
  output logic        [DATA_WIDTH-1:0] din0,
  output logic                         csb1,
  output logic        [ADDR_WIDTH-1:0] addr1,
  input  logic        [DATA_WIDTH-1:0] dout1
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

  state_t                         state;
  logic        [ADDR_WIDTH-1:0]   wr_ptr;
  logic        [ADDR_WIDTH-1:0]   fill_cnt;
  logic                           rd_en_p0;
  logic                           byp_p0;
  logic signed [DATA_WIDTH-1:0]   dry_p0;
  logic signed [DATA_WIDTH-1:0]   wet_p1;
  logic                           accept;
  logic                           rd_ok;

`ifdef DELAY_MIX_EN
  function automatic logic signed [DATA_WIDTH-1:0] mix_sat(
    input logic signed [DATA_WIDTH-1:0] dry,
    input logic signed [DATA_WIDTH-1:0] wet
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = {dry[DATA_WIDTH-1], dry} + {{2{wet[DATA_WIDTH-1]}}, wet[DATA_WIDTH-1:1]};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      mix_sat = {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}};
    else
      mix_sat = sum[DATA_WIDTH-1:0];
  endfunction
`endif

  assign accept = (state == S_IDLE) && in_valid && in_ready;
  // A read is only issued for history that has actually been written since reset.
  assign rd_ok  = (delay_len != '0) && (delay_len <= fill_cnt);

  // Stage p0: dry sample captured on accept
  always_ff @(posedge clk) begin
    if (accept) dry_p0 <= in_sample;
  end

  // Stage p1: wet value selected from SRAM read, bypass or unfilled zero
  always_comb begin
    wet_p1 = '0;
    if (rd_en_p0)    wet_p1 = $signed(dout1);
    else if (byp_p0) wet_p1 = dry_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      csb1       <= 1'b1;
      addr0      <= '0;
      addr1      <= '0;
      din0       <= '0;
      rd_en_p0   <= 1'b0;
      byp_p0     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          out_valid <= 1'b0;
          if (accept) begin
            state    <= S_ISSUE;
            in_ready <= 1'b0;
            csb0     <= 1'b0;
            web0     <= 1'b0;
            addr0    <= wr_ptr;
            din0     <= in_sample;
            addr1    <= wr_ptr - delay_len;
            csb1     <= ~rd_ok;
            rd_en_p0 <= rd_ok;
            byp_p0   <= (delay_len == '0);
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          state  <= S_WAIT;
          csb0   <= 1'b1;
          web0   <= 1'b1;
          csb1   <= 1'b1;
          wr_ptr <= wr_ptr + PTR_ONE;
          if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + PTR_ONE;
        end
        S_WAIT: begin
          state     <= S_OUT;
          out_valid <= 1'b1;
`ifdef DELAY_MIX_EN
          out_sample <= mix_sat(dry_p0, wet_p1);
`else
          out_sample <= wet_p1;
`endif
        end
        S_OUT: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
